controller_status_port: RTL and testbench

// - FPGA-side engine on controller BRAM: publishes version/state to host, pulls control flag + silencer regs.
// - Between controller BRAM (FPGA port) and core: drives FORCE_FAN, sync request, silencer shadow settings.

---
 rtl/controller_status_port.sv | 244 ++++++++++++++++++++++++
 tb/tb_controller_status_port.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_status_port.sv
// controller_status_port
//   FPGA-side engine on the controller BRAM port. After reset it publishes
//   the version words once. It then loops over poll rounds: read the control
//   flag, publish the FPGA state word, and either pull the silencer registers
//   (on a SET rising edge) or idle for POLL_INTERVAL cycles.
//
// Parameters
//   RD_LATENCY     BRAM read latency (edge that samples the address -> data valid), 1..3
//   POLL_INTERVAL  idle cycles between poll rounds, 0 = back-to-back rounds
//
// Build option
//   CTL_STATUS_HEARTBEAT_EN  when defined, the state word is {round_cnt, fpga_state[7:0]}
//                            and it is written every round.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   bram_en/we/addr/din/dout   controller BRAM port (registered outputs)
//   fpga_state                 state word to publish at 0x01
//   ctl_flag, force_fan        last captured control flag word and its bit 13
//   sync_req                   1-cycle pulse on a 0->1 edge of captured flag bit 15
//   silencer_*                 silencer shadow registers (0x40..0x44)
//   silencer_update            1-cycle pulse when all shadows are committed together
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_VER_MAJ   | write major version to 0x30 (once per reset)
// ST_VER_MIN   | write minor version to 0x31 (once per reset)
// ST_RD_FLAG   | issue the control flag read at 0x00
// ST_FLAG_WAIT | wait for the flag data, capture it
// ST_WR_STATE  | publish the state word at 0x01 when needed (always 1 cycle)
// ST_SHADOW    | pipelined reads of 0x40..0x44, then commit all shadows at once
// ST_WAIT      | idle POLL_INTERVAL cycles, no BRAM access
module controller_status_port #(
  parameter int RD_LATENCY    = 2,
  parameter int POLL_INTERVAL = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        bram_en,
  output logic        bram_we,
  output logic [7:0]  bram_addr,
  output logic [15:0] bram_din,
  input  logic [15:0] bram_dout,
  input  logic [15:0] fpga_state,
  output logic [15:0] ctl_flag,
  output logic        force_fan,
  output logic        sync_req,
  output logic        silencer_mode,
  output logic [15:0] silencer_ur_int,
  output logic [15:0] silencer_ur_phase,
  output logic [15:0] silencer_cs_int,
  output logic [15:0] silencer_cs_phase,
  output logic        silencer_update
);

  localparam logic [7:0] ADDR_CTL_FLAG   = 8'h00;
  localparam logic [7:0] ADDR_FPGA_STATE = 8'h01;
  localparam logic [7:0] ADDR_VER_MAJ    = 8'h30;
  localparam logic [7:0] ADDR_VER_MIN    = 8'h31;
  localparam logic [7:0] ADDR_SILENCER   = 8'h40;
  localparam logic [7:0] VERSION_NUM     = 8'h8F;
  localparam int CTL_FLAG_FORCE_FAN_BIT  = 13;
  localparam int CTL_FLAG_SET_BIT        = 14;
  localparam int CTL_FLAG_SYNC_BIT       = 15;
  localparam logic [2:0] SHADOW_WORDS    = 3'd5;

  localparam int WAIT_W = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((POLL_INTERVAL > 0) ? POLL_INTERVAL - 1 : 0);

  typedef enum logic [2:0] {
    ST_VER_MAJ,
    ST_VER_MIN,
    ST_RD_FLAG,
    ST_FLAG_WAIT,
    ST_WR_STATE,
    ST_SHADOW,
    ST_WAIT
  } state_t;

  state_t                state_q, state_nxt;
  logic                  en_nxt, we_nxt;
  logic [7:0]            addr_nxt;
  logic [15:0]           din_nxt;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic                  rd_cap;
  logic                  shadow_pend;
  logic [2:0]            sh_iss_cnt, sh_cap_cnt;
  logic [3:0][15:0]      stage;
  logic                  stage_mode;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [15:0]           state_word;
  logic                  state_wr_need;

`ifdef CTL_STATUS_HEARTBEAT_EN
  logic [7:0] round_cnt;
  assign state_word    = {round_cnt, fpga_state[7:0]};
  assign state_wr_need = 1'b1;
`else
  logic [15:0] last_word;
  logic        last_valid;
  assign state_word    = fpga_state;
  assign state_wr_need = !last_valid || (state_word != last_word);
`endif

  // Each read tag travels RD_LATENCY edges after the BRAM samples the address.
  assign rd_cap    = rd_pipe[RD_LATENCY-1];
  assign force_fan = ctl_flag[CTL_FLAG_FORCE_FAN_BIT];

  always_comb begin
    state_nxt = state_q;
    en_nxt    = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = '0;
    din_nxt   = '0;
    case (state_q)
      ST_VER_MAJ: begin
        en_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = ADDR_VER_MAJ;
        din_nxt   = {8'h00, VERSION_NUM};
        state_nxt = ST_VER_MIN;
      end
      ST_VER_MIN: begin
        en_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = ADDR_VER_MIN;
        state_nxt = ST_RD_FLAG;
      end
      ST_RD_FLAG: begin
        en_nxt    = 1'b1;
        addr_nxt  = ADDR_CTL_FLAG;
        state_nxt = ST_FLAG_WAIT;
      end
      ST_FLAG_WAIT: begin
        if (rd_cap) state_nxt = ST_WR_STATE;
      end
      ST_WR_STATE: begin
        if (state_wr_need) begin
          en_nxt   = 1'b1;
          we_nxt   = 1'b1;
          addr_nxt = ADDR_FPGA_STATE;
          din_nxt  = state_word;
        end
        if (shadow_pend)             state_nxt = ST_SHADOW;
        else if (POLL_INTERVAL == 0) state_nxt = ST_RD_FLAG;
        else                         state_nxt = ST_WAIT;
      end
      ST_SHADOW: begin
        if (sh_iss_cnt != SHADOW_WORDS) begin
          en_nxt   = 1'b1;
          addr_nxt = ADDR_SILENCER + {5'd0, sh_iss_cnt};
        end
        if (sh_cap_cnt == SHADOW_WORDS) state_nxt = ST_RD_FLAG;
      end
      ST_WAIT: begin
        if (wait_cnt == '0) state_nxt = ST_RD_FLAG;
      end
      default: state_nxt = ST_VER_MAJ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_VER_MAJ;
      bram_en           <= 1'b0;
      bram_we           <= 1'b0;
      bram_addr         <= '0;
      bram_din          <= '0;
      rd_pipe           <= '0;
      ctl_flag          <= '0;
      sync_req          <= 1'b0;
      shadow_pend       <= 1'b0;
      sh_iss_cnt        <= '0;
      sh_cap_cnt        <= '0;
      stage             <= '0;
      stage_mode        <= 1'b0;
      wait_cnt          <= '0;
      silencer_mode     <= 1'b0;
      silencer_ur_int   <= '0;
      silencer_ur_phase <= '0;
      silencer_cs_int   <= '0;
      silencer_cs_phase <= '0;
      silencer_update   <= 1'b0;
`ifdef CTL_STATUS_HEARTBEAT_EN
      round_cnt         <= '0;
`else
      last_word         <= '0;
      last_valid        <= 1'b0;
`endif
    end else begin
      state_q         <= state_nxt;
      bram_en         <= en_nxt;
      bram_we         <= we_nxt;
      bram_addr       <= addr_nxt;
      bram_din        <= din_nxt;
      rd_pipe         <= (rd_pipe << 1) | RD_LATENCY'(bram_en & ~bram_we);
      sync_req        <= 1'b0;
      silencer_update <= 1'b0;

      // ctl_flag still holds the previous capture, so it doubles as the edge reference.
      if (state_q == ST_FLAG_WAIT && rd_cap) begin
        ctl_flag    <= bram_dout;
        sync_req    <= bram_dout[CTL_FLAG_SYNC_BIT] & ~ctl_flag[CTL_FLAG_SYNC_BIT];
        shadow_pend <= bram_dout[CTL_FLAG_SET_BIT] & ~ctl_flag[CTL_FLAG_SET_BIT];
      end

      if (state_q == ST_WR_STATE) begin
        wait_cnt <= WAIT_LOAD;
`ifdef CTL_STATUS_HEARTBEAT_EN
        round_cnt <= round_cnt + 8'd1;
`else
        if (state_wr_need) begin
          last_word  <= state_word;
          last_valid <= 1'b1;
        end
`endif
      end else if (state_q == ST_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end

      if (state_q == ST_SHADOW) begin
        if (sh_iss_cnt != SHADOW_WORDS) sh_iss_cnt <= sh_iss_cnt + 3'd1;
        if (rd_cap) begin
          // Words arrive in address order; the oldest falls out into the mode bit.
          stage_mode <= stage[3][0];
          stage      <= {stage[2:0], bram_dout};
          sh_cap_cnt <= sh_cap_cnt + 3'd1;
        end
        if (sh_cap_cnt == SHADOW_WORDS) begin
          silencer_mode     <= stage_mode;
          silencer_ur_int   <= stage[3];
          silencer_ur_phase <= stage[2];
          silencer_cs_int   <= stage[1];
          silencer_cs_phase <= stage[0];
          silencer_update   <= 1'b1;
        end
      end else begin
        sh_iss_cnt <= '0;
        sh_cap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_controller_status_port.sv
module tb_controller_status_port;

  localparam int RD_LAT = 2;
  localparam int POLL   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bram_en, bram_we;
  logic [7:0]  bram_addr;
  logic [15:0] bram_din, bram_dout;
  logic [15:0] fpga_state;
  logic [15:0] ctl_flag;
  logic        force_fan, sync_req, silencer_mode, silencer_update;
  logic [15:0] silencer_ur_int, silencer_ur_phase, silencer_cs_int, silencer_cs_phase;

  controller_status_port #(.RD_LATENCY(RD_LAT), .POLL_INTERVAL(POLL)) dut (
    .clk(clk), .rst_n(rst_n),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout),
    .fpga_state(fpga_state), .ctl_flag(ctl_flag), .force_fan(force_fan),
    .sync_req(sync_req), .silencer_mode(silencer_mode),
    .silencer_ur_int(silencer_ur_int), .silencer_ur_phase(silencer_ur_phase),
    .silencer_cs_int(silencer_cs_int), .silencer_cs_phase(silencer_cs_phase),
    .silencer_update(silencer_update)
  );

  always #5 clk = ~clk;

  // Host-side BRAM contents (what the DUT reads) and a read pipeline of RD_LAT stages.
  logic [15:0] host_mem [256];
  logic [15:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    if (bram_en && !bram_we) rpipe[0] <= host_mem[bram_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bram_dout = rpipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;
  int ver_cnt = 0;
  int upd_cnt = 0;
  int bad_cnt = 0;
  logic [15:0] st_q [$];

  always @(negedge clk) begin
    if (bram_en && bram_we) begin
      if (bram_addr == 8'h30) ver_cnt = ver_cnt + 1;
      if (bram_addr == 8'h01) st_q.push_back(bram_din);
    end
    if (bram_we && !bram_en) bad_cnt = bad_cnt + 1;
    if (silencer_update) upd_cnt = upd_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Finds the next flag read issue, then returns #1 after the capture edge.
  task automatic wait_flag_capture(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (bram_en && !bram_we && bram_addr == 8'h00) ok = 1'b1;
    end
    if (ok) begin
      repeat (RD_LAT + 1) @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: flag read timeout", name);
    end
  endtask

  task automatic wait_update(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (silencer_update) ok = 1'b1;
    end
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: silencer_update timeout", name);
    end
  endtask

  task automatic set_shadow(input logic [15:0] a, b, c, d, e);
    host_mem[8'h40] = a; host_mem[8'h41] = b; host_mem[8'h42] = c;
    host_mem[8'h43] = d; host_mem[8'h44] = e;
  endtask

  typedef struct {
    logic [15:0] flag;
    logic        exp_ff;
    logic        exp_sync;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int u0, v0;
    vecs[0] = '{16'h2000, 1'b1, 1'b0};
    vecs[1] = '{16'h0000, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 1'b0, 1'b0};
    vecs[4] = '{16'hA000, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'hA000, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 1'b0, 1'b0};

    for (int i = 0; i < 256; i++) host_mem[i] = 16'h0000;
    for (int i = 0; i < RD_LAT; i++) rpipe[i] = 16'h0000;
    rst_n = 1'b0;
`ifdef CTL_STATUS_HEARTBEAT_EN
    fpga_state = 16'h00AA;
`else
    fpga_state = 16'h0001;
`endif

    repeat (3) @(negedge clk);
    check("rst_bram", 32'({bram_en, bram_we, bram_addr, bram_din}), 32'h0);
    check("rst_flag", 32'({ctl_flag, force_fan, sync_req, silencer_update}), 32'h0);
    check("rst_shadow", 32'({silencer_mode, silencer_ur_int, silencer_cs_phase}), 32'h0);

    rst_n = 1'b1;
    @(negedge clk);
    check("ver_maj", 32'({bram_en, bram_we, bram_addr, bram_din}), {6'd0, 1'b1, 1'b1, 8'h30, 16'h008F});
    @(negedge clk);
    check("ver_min", 32'({bram_en, bram_we, bram_addr, bram_din}), {6'd0, 1'b1, 1'b1, 8'h31, 16'h0000});
    @(negedge clk);
    check("rd_flag", 32'({bram_en, bram_we, bram_addr}), {22'd0, 1'b1, 1'b0, 8'h00});

    for (int i = 0; i < 8; i++) begin
      host_mem[0] = vecs[i].flag;
      wait_flag_capture($sformatf("vec%0d", i));
      check($sformatf("vec%0d_ctl_flag", i), 32'(ctl_flag), 32'(vecs[i].flag));
      check($sformatf("vec%0d_force_fan", i), 32'(force_fan), 32'(vecs[i].exp_ff));
      check($sformatf("vec%0d_sync_req", i), 32'(sync_req), 32'(vecs[i].exp_sync));
    end

`ifdef CTL_STATUS_HEARTBEAT_EN
    check("hb_first", 32'(st_q[0]), 32'h00AA);
    check("hb_second", 32'(st_q[1]), 32'h01AA);
    for (int i = 0; i < 20000 && st_q.size() < 258; i++) @(posedge clk);
    #1;
    check("hb_rounds", 32'(st_q.size() >= 258), 32'd1);
    check("hb_wrap", 32'(st_q[256]), 32'h00AA);
    check("hb_after_wrap", 32'(st_q[257]), 32'h01AA);
`else
    check("st_single_cnt", 32'(st_q.size()), 32'd1);
    check("st_single_val", 32'(st_q[0]), 32'h0001);
    fpga_state = 16'h0003;
    wait_flag_capture("st_chg_a");
    wait_flag_capture("st_chg_b");
    repeat (4) @(posedge clk);
    #1;
    check("st_chg_cnt", 32'(st_q.size()), 32'd2);
    check("st_chg_val", 32'(st_q[1]), 32'h0003);
`endif

    set_shadow(16'd1, 16'd256, 16'd256, 16'd10, 16'd40);
    host_mem[0] = 16'h4000;
    wait_flag_capture("sh1_flag");
    wait_update("sh1");
    check("sh1_mode", 32'(silencer_mode), 32'd1);
    check("sh1_ur", {silencer_ur_int, silencer_ur_phase}, {16'd256, 16'd256});
    check("sh1_cs", {silencer_cs_int, silencer_cs_phase}, {16'd10, 16'd40});
    check("sh1_cnt", 32'(upd_cnt), 32'd1);

    set_shadow(16'd0, 16'd5, 16'd6, 16'd7, 16'd8);
    for (int r = 0; r < 3; r++) wait_flag_capture("sh_hold");
    repeat (20) @(posedge clk);
    #1;
    check("sh_hold_cnt", 32'(upd_cnt), 32'd1);
    check("sh_hold_ur", {silencer_ur_int, silencer_ur_phase}, {16'd256, 16'd256});

    host_mem[0] = 16'h0000;
    wait_flag_capture("sh2_clr");
    host_mem[0] = 16'h4000;
    wait_flag_capture("sh2_flag");
    wait_update("sh2");
    check("sh2_mode", 32'(silencer_mode), 32'd0);
    check("sh2_ur", {silencer_ur_int, silencer_ur_phase}, {16'd5, 16'd6});
    check("sh2_cs", {silencer_cs_int, silencer_cs_phase}, {16'd7, 16'd8});
    check("sh2_cnt", 32'(upd_cnt), 32'd2);

    host_mem[0] = 16'h0000;
    wait_flag_capture("sh3_clr");
    set_shadow(16'd1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    host_mem[0] = 16'hC000;
    wait_flag_capture("sh3_flag");
    check("sh3_sync", 32'(sync_req), 32'd1);
    wait_update("sh3");
    check("sh3_cs", {silencer_cs_int, silencer_cs_phase}, {16'h3333, 16'h4444});
    check("sh3_cnt", 32'(upd_cnt), 32'd3);
    check("ver_once", 32'(ver_cnt), 32'd1);
`ifndef CTL_STATUS_HEARTBEAT_EN
    check("st_no_rewrite", 32'(st_q.size()), 32'd2);
`endif

    host_mem[0] = 16'h0000;
    wait_flag_capture("rst_clr");
    set_shadow(16'd1, 16'd9, 16'd9, 16'd9, 16'd9);
    host_mem[0] = 16'h4000;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (bram_en && !bram_we && bram_addr == 8'h42) found = 1'b1;
    end
    check("rst_sh_found", 32'(found), 32'd1);
    u0 = upd_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_flag", 32'({ctl_flag, bram_en, sync_req}), 32'h0);
    check("rst_mid_ur", {silencer_ur_int, silencer_ur_phase}, 32'h0);
    check("rst_mid_cs", {silencer_cs_int, silencer_cs_phase}, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_mid_noupd", 32'(upd_cnt), 32'(u0));
    v0 = ver_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ver_maj", 32'({bram_en, bram_we, bram_addr, bram_din}), {6'd0, 1'b1, 1'b1, 8'h30, 16'h008F});
    @(negedge clk);
    check("rst_ver_min", 32'({bram_en, bram_we, bram_addr}), {22'd0, 1'b1, 1'b1, 8'h31});
    #1;
    check("rst_ver_cnt", 32'(ver_cnt), 32'(v0 + 1));
    wait_update("rst_sh");
    check("rst_sh_ur", {silencer_ur_int, silencer_cs_phase}, {16'd9, 16'd9});
    check("we_without_en", 32'(bad_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
